// File: rtl/rtr_lar_pipe.sv
// Lookahead route stage for phased-DOR mesh routers: computes the next router's {port, rcsel}
// for head flits, holds it for the rest of the packet, and outputs through a 2-entry skid buffer.
// Optional protocol checker enabled by defining RTR_LAR_PIPE_CHECK_EN.
module rtr_lar_pipe #(
    parameter int unsigned num_resource_classes = 2,
    parameter int unsigned num_routers_per_dim  = 4,
    parameter int unsigned num_dimensions       = 2,
    parameter int unsigned num_nodes_per_router = 1,
    localparam int unsigned dim_addr_width    = $clog2(num_routers_per_dim),
    localparam int unsigned router_addr_width = num_dimensions * dim_addr_width,
    localparam int unsigned node_addr_width   = $clog2(num_nodes_per_router),
    localparam int unsigned dest_info_width   = num_resource_classes * router_addr_width + node_addr_width,
    localparam int unsigned port_idx_width    = $clog2(2 * num_dimensions + num_nodes_per_router),
    localparam int unsigned rc_width          = $clog2(num_resource_classes),
    localparam int unsigned lar_info_width    = port_idx_width + rc_width
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [router_addr_width-1:0] next_router_address,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_head,
    input  logic                         in_tail,
    input  logic [dest_info_width-1:0]   in_dest_info,
    input  logic [lar_info_width-1:0]    in_lar_info,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_head,
    output logic                         out_tail,
    output logic [dest_info_width-1:0]   out_dest_info,
    output logic [lar_info_width-1:0]    out_lar_info,
    output logic                         error
);

    localparam int unsigned node_sel_width = (node_addr_width > 0) ? node_addr_width : 1;

    typedef enum logic [0:0] {IDLE, IN_PKT} state_t;

    state_t state, state_nxt;

    logic accept_c;
    logic drain_c;
    assign accept_c = in_valid && in_ready;
    assign drain_c  = out_valid && out_ready;

    logic [rc_width-1:0] cur_rc;
    logic                unused_cur_port;
    assign cur_rc          = in_lar_info[rc_width-1:0];
    assign unused_cur_port = ^in_lar_info[lar_info_width-1:rc_width];

    logic [node_sel_width-1:0] node_addr;
    generate
        if (node_addr_width > 0) begin : g_node
            assign node_addr = in_dest_info[node_sel_width-1:0];
        end else begin : g_no_node
            assign node_addr = '0;
        end
    endgenerate

    // Route for the flit at the next router; ejects when every remaining class already matches
    logic                         rc_found;
    logic                         dim_found;
    logic [rc_width-1:0]          sel_rc;
    logic [router_addr_width-1:0] sel_dest;
    logic [port_idx_width-1:0]    route_port;
    logic [lar_info_width-1:0]    route_lar;

    always_comb begin
        rc_found   = 1'b0;
        dim_found  = 1'b0;
        sel_rc     = rc_width'(num_resource_classes - 1);
        sel_dest   = '0;
        route_port = port_idx_width'(2 * num_dimensions) + port_idx_width'(node_addr);
        for (int k = 0; k < int'(num_resource_classes); k++) begin
            if (!rc_found && (k >= int'(cur_rc)) &&
                (in_dest_info[k*router_addr_width +: router_addr_width] != next_router_address)) begin
                rc_found = 1'b1;
                sel_rc   = rc_width'(k);
                sel_dest = in_dest_info[k*router_addr_width +: router_addr_width];
            end
        end
        for (int d = 0; d < int'(num_dimensions); d++) begin
            if (rc_found && !dim_found &&
                (sel_dest[d*dim_addr_width +: dim_addr_width] !=
                 next_router_address[d*dim_addr_width +: dim_addr_width])) begin
                dim_found  = 1'b1;
                route_port = (sel_dest[d*dim_addr_width +: dim_addr_width] <
                              next_router_address[d*dim_addr_width +: dim_addr_width])
                             ? port_idx_width'(2 * d) : port_idx_width'(2 * d + 1);
            end
        end
        route_lar = {route_port, sel_rc};
    end

    logic [lar_info_width-1:0] held_lar;
    logic [lar_info_width-1:0] flit_lar;
    assign flit_lar = in_head ? route_lar : held_lar;

    // Packet state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Packet next-state: a head opens a packet unless it is also the tail
    always_comb begin
        state_nxt = state;
        if (accept_c) begin
            if (in_head) begin
                state_nxt = in_tail ? IDLE : IN_PKT;
            end else if (in_tail) begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            held_lar <= '0;
        end else if (accept_c && in_head) begin
            held_lar <= route_lar;
        end
    end

    // Output register plus one skid entry; in_ready mirrors the next skid-empty state
    logic                       skid_valid;
    logic                       skid_head;
    logic                       skid_tail;
    logic [dest_info_width-1:0] skid_dest_info;
    logic [lar_info_width-1:0]  skid_lar_info;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid      <= 1'b0;
            out_head       <= 1'b0;
            out_tail       <= 1'b0;
            out_dest_info  <= '0;
            out_lar_info   <= '0;
            skid_valid     <= 1'b0;
            skid_head      <= 1'b0;
            skid_tail      <= 1'b0;
            skid_dest_info <= '0;
            skid_lar_info  <= '0;
            in_ready       <= 1'b1;
        end else if (skid_valid) begin
            if (drain_c) begin
                out_head      <= skid_head;
                out_tail      <= skid_tail;
                out_dest_info <= skid_dest_info;
                out_lar_info  <= skid_lar_info;
                skid_valid    <= 1'b0;
                in_ready      <= 1'b1;
            end
        end else if (accept_c) begin
            if (!out_valid || out_ready) begin
                out_valid     <= 1'b1;
                out_head      <= in_head;
                out_tail      <= in_tail;
                out_dest_info <= in_dest_info;
                out_lar_info  <= flit_lar;
            end else begin
                skid_valid     <= 1'b1;
                skid_head      <= in_head;
                skid_tail      <= in_tail;
                skid_dest_info <= in_dest_info;
                skid_lar_info  <= flit_lar;
                in_ready       <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RTR_LAR_PIPE_CHECK_EN
    // Sticky flag for a head inside a packet or a body/tail outside one
    always_ff @(posedge clk) begin
        if (!reset) begin
            error <= 1'b0;
        end else if (accept_c && ((in_head && (state == IN_PKT)) ||
                                  (!in_head && (state == IDLE)))) begin
            error <= 1'b1;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_rtr_lar_pipe.sv
// Self-checking bench for rtr_lar_pipe: scoreboard on output handshakes plus per-scenario checks.
module tb_rtr_lar_pipe;

    logic       clk;
    logic       reset;
    logic [3:0] next_router_address;
    logic       in_valid;
    logic       in_ready;
    logic       in_head;
    logic       in_tail;
    logic [7:0] in_dest_info;
    logic [3:0] in_lar_info;
    logic       out_valid;
    logic       out_ready;
    logic       out_head;
    logic       out_tail;
    logic [7:0] out_dest_info;
    logic [3:0] out_lar_info;
    logic       error;

    typedef struct packed {
        logic       head;
        logic       tail;
        logic [7:0] dest;
        logic [3:0] lar;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_exp;
    logic [3:0] tb_held;
    int         errors  = 0;
    int         checks  = 0;
    int         accepts = 0;
    int         drains  = 0;

`ifdef RTR_LAR_PIPE_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    rtr_lar_pipe dut (
        .clk                 (clk),
        .reset               (reset),
        .next_router_address (next_router_address),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_head             (in_head),
        .in_tail             (in_tail),
        .in_dest_info        (in_dest_info),
        .in_lar_info         (in_lar_info),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_head            (out_head),
        .out_tail            (out_tail),
        .out_dest_info       (out_dest_info),
        .out_lar_info        (out_lar_info),
        .error               (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address digits {dim0, dim1}; dim0 occupies the low bits
    function automatic logic [3:0] mk(input int d0, input int d1);
        return {2'(d1), 2'(d0)};
    endfunction

    // Reference route: skip classes whose destination equals the next router, then DOR
    function automatic logic [3:0] model_lar(input logic [3:0] nxt, input logic [7:0] dst, input logic rc);
        int         r;
        int         dd0, dd1, nd0, nd1;
        logic [3:0] da;
        r = int'(rc);
        while (r < 2) begin
            da = dst[r*4 +: 4];
            if (da != nxt) break;
            r++;
        end
        if (r >= 2) return 4'b1001;
        da  = dst[r*4 +: 4];
        dd0 = int'(da[1:0]);
        dd1 = int'(da[3:2]);
        nd0 = int'(nxt[1:0]);
        nd1 = int'(nxt[3:2]);
        if (dd0 != nd0) return {(dd0 < nd0) ? 3'd0 : 3'd1, r == 1};
        return {(dd1 < nd1) ? 3'd2 : 3'd3, r == 1};
    endfunction

    // Scoreboard: pop/compare on output handshake, push on input accept
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            tb_held = 4'd0;
        end else begin
            if (out_valid && out_ready) begin
                drains++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got flit h=%b t=%b dest=%h lar=%b, required none",
                             out_head, out_tail, out_dest_info, out_lar_info);
                end else begin
                    mon_exp = sb.pop_front();
                    if ({out_head, out_tail, out_dest_info, out_lar_info} !== mon_exp) begin
                        errors++;
                        $display("FAIL sb_flit: got h=%b t=%b dest=%h lar=%b, required h=%b t=%b dest=%h lar=%b",
                                 out_head, out_tail, out_dest_info, out_lar_info,
                                 mon_exp.head, mon_exp.tail, mon_exp.dest, mon_exp.lar);
                    end
                end
            end
            if (in_valid && in_ready) begin
                accepts++;
                if (in_head) tb_held = model_lar(next_router_address, in_dest_info, in_lar_info[0]);
                sb.push_back('{head: in_head, tail: in_tail, dest: in_dest_info, lar: tb_held});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_flit(input logic h, input logic t, input logic [3:0] nxt,
                            input logic [7:0] dst, input logic [3:0] lar);
        in_valid            = 1'b1;
        in_head             = h;
        in_tail             = t;
        next_router_address = nxt;
        in_dest_info        = dst;
        in_lar_info         = lar;
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b required 0", error); end
        checks++;
        if ({out_head, out_tail, out_dest_info, out_lar_info} !== 14'd0) begin
            errors++;
            $display("FAIL rst_data: got h=%b t=%b dest=%h lar=%b required all 0",
                     out_head, out_tail, out_dest_info, out_lar_info);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %b required 0", out_valid); end
    endtask

    task automatic test_route;
        logic [3:0] nx[3];
        logic [7:0] ds[3];
        logic       rcs[3];
        logic [3:0] ex[3];
        nx[0] = mk(1, 2); ds[0] = {mk(0, 0), mk(0, 2)}; rcs[0] = 1'b0; ex[0] = 4'b0000;
        nx[1] = mk(1, 2); ds[1] = {mk(3, 2), mk(1, 2)}; rcs[1] = 1'b0; ex[1] = 4'b0011;
        nx[2] = mk(1, 2); ds[2] = {mk(1, 2), mk(2, 2)}; rcs[2] = 1'b1; ex[2] = 4'b1001;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_flit(1'b1, 1'b1, nx[i], ds[i], {3'b000, rcs[i]});
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_lar_info !== ex[i]) begin
                errors++;
                $display("FAIL route_%0d: got valid=%b lar=%b required valid=1 lar=%b",
                         i, out_valid, out_lar_info, ex[i]);
            end
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            set_flit(1'b1, 1'b1, 4'($urandom), 8'($urandom), 4'($urandom));
            if (i[0]) in_dest_info[3:0] = next_router_address;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_packet;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) set_flit(1'b1, 1'b0, mk(1, 2), {mk(3, 3), mk(1, 0)}, 4'b0000);
            else        set_flit(1'b0, i == 3, 4'($urandom), 8'($urandom), 4'($urandom));
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_lar_info !== 4'b0100 ||
                out_head !== (i == 0) || out_tail !== (i == 3)) begin
                errors++;
                $display("FAIL pkt_flit_%0d: got valid=%b h=%b t=%b lar=%b required valid=1 h=%b t=%b lar=0100",
                         i, out_valid, out_head, out_tail, out_lar_info, i == 0, i == 3);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall;
        int abase;
        int dbase;
        abase     = accepts;
        dbase     = drains;
        out_ready = 1'b1;
        set_flit(1'b1, 1'b0, mk(0, 0), {mk(0, 0), mk(3, 1)}, 4'b0000);
        tick();
        out_ready = 1'b0;
        set_flit(1'b0, 1'b0, 4'h7, 8'hA5, 4'hF);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_dest_info !== {mk(0, 0), mk(3, 1)}) begin
            errors++;
            $display("FAIL stall_1: got in_ready=%b dest=%h required in_ready=0 dest=%h",
                     in_ready, out_dest_info, {mk(0, 0), mk(3, 1)});
        end
        set_flit(1'b0, 1'b1, 4'h3, 8'h5A, 4'h6);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_dest_info !== {mk(0, 0), mk(3, 1)}) begin
            errors++;
            $display("FAIL stall_2: got in_ready=%b valid=%b dest=%h required 0 1 %h",
                     in_ready, out_valid, out_dest_info, {mk(0, 0), mk(3, 1)});
        end
        tick();
        checks++;
        if (accepts - abase !== 2) begin
            errors++;
            $display("FAIL stall_buffered: got %0d flits accepted required 2", accepts - abase);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_dest_info !== 8'hA5 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got dest=%h in_ready=%b required dest=a5 in_ready=1",
                     out_dest_info, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_dest_info !== 8'h5A || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_third: got dest=%h valid=%b required dest=5a valid=1", out_dest_info, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || drains - dbase !== 3 || sb.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: got valid=%b drained=%0d pending=%0d required 0 3 0",
                     out_valid, drains - dbase, sb.size());
        end
    endtask

    task automatic test_random;
        int         len;
        int         waitc;
        logic [3:0] nx;
        logic [7:0] ds;
        logic       rc;
        logic       acc;
        for (int p = 0; p < 25; p++) begin
            len = int'($urandom_range(1, 4));
            nx  = 4'($urandom);
            ds  = 8'($urandom);
            if ($urandom_range(0, 2) == 0) ds[3:0] = nx;
            rc  = 1'($urandom);
            for (int f = 0; f < len; f++) begin
                if (f == 0) set_flit(1'b1, len == 1, nx, ds, {3'($urandom), rc});
                else        set_flit(1'b0, f == len - 1, 4'($urandom), 8'($urandom), 4'($urandom));
                waitc = 0;
                do begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    acc       = in_ready;
                    tick();
                    waitc++;
                end while (!acc && waitc < 50);
                checks++;
                if (!acc) begin
                    errors++;
                    $display("FAIL rand_accept: got no accept in %0d cycles required accept", waitc);
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitc     = 0;
        while ((sb.size() != 0 || out_valid) && waitc < 20) begin
            tick();
            waitc++;
        end
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: got pending=%0d valid=%b required 0 0", sb.size(), out_valid);
        end
    endtask

    task automatic test_error_reset;
        out_ready = 1'b1;
        set_flit(1'b0, 1'b0, 4'h1, 8'h33, 4'h0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (error !== EXP_ERR) begin errors++; $display("FAIL err_set: got %b required %b", error, EXP_ERR); end
        tick();
        tick();
        checks++;
        if (error !== EXP_ERR) begin errors++; $display("FAIL err_sticky: got %b required %b", error, EXP_ERR); end
        set_flit(1'b1, 1'b0, mk(1, 1), {mk(2, 2), mk(0, 1)}, 4'h0);
        tick();
        set_flit(1'b0, 1'b0, 4'h9, 8'hC3, 4'h2);
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || error !== 1'b0 || out_lar_info !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b in_ready=%b error=%b lar=%b required 0 1 0 0000",
                     out_valid, in_ready, error, out_lar_info);
        end
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b required 0", out_valid); end
    endtask

    initial begin
        reset               = 1'b0;
        in_valid            = 1'b0;
        in_head             = 1'b0;
        in_tail             = 1'b0;
        next_router_address = 4'd0;
        in_dest_info        = 8'd0;
        in_lar_info         = 4'd0;
        out_ready           = 1'b0;
        test_reset();
        test_route();
        test_packet();
        test_stall();
        test_random();
        test_error_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtr_lar_pipe.md
# rtr_lar_pipe

Per-input-port lookahead routing stage for phased-DOR routers on line-connected (mesh) dimensions. It sits directly downstream of the next-hop address logic. For each head flit it takes the computed address of the next router together with the flit's destination info, and computes the route (output port plus resource class) that flit will take at that next router. Results are registered, held for the body and tail flits of the packet, and delivered through a 2-entry skid buffer with a valid/ready handshake.

## Interface

**Parameters**

- `num_resource_classes`, 2: resource classes in `dest_info`.
- `num_routers_per_dim`, 4: routers per dimension.
- `num_dimensions`, 2: network dimensions.
- `num_nodes_per_router`, 1: concentration factor.
- Derived values:
  - `dim_addr_width` = clogb(`num_routers_per_dim`).
  - `router_addr_width` = `num_dimensions`·`dim_addr_width`.
  - `node_addr_width` = clogb(`num_nodes_per_router`).
  - `dest_info_width` = `num_resource_classes`·`router_addr_width` + `node_addr_width`.
  - `port_idx_width` = clogb(2·`num_dimensions` + `num_nodes_per_router`).
  - `lar_info_width` = `port_idx_width` + clogb(`num_resource_classes`).

**Ports**

- `clk` input 1: clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `next_router_address` input `router_addr_width`: next router address for the flit currently on the input; valid when `in_valid`.
- `in_valid` input 1: input flit valid.
- `in_ready` output 1: stage can accept a flit.
- `in_head` input 1: head flit marker.
- `in_tail` input 1: tail flit marker; a single-flit packet has both `in_head` and `in_tail` set.
- `in_dest_info` input `dest_info_width`: destination info; meaningful on head flits only.
- `in_lar_info` input `lar_info_width`: current-router route `{port, rcsel}`.
- `out_valid` output 1: output flit valid.
- `out_ready` input 1: downstream accepts the output flit.
- `out_head` output 1: head marker, passed through from input.
- `out_tail` output 1: tail marker, passed through from input.
- `out_dest_info` output `dest_info_width`: destination info, passed through from input.
- `out_lar_info` output `lar_info_width`: next-router route `{port, rcsel}`.
- `error` output 1: sticky protocol error (see Configuration).

## Operation

**Route computation (head flits, combinational, registered on accept)**

- Let `rc` = `in_lar_info` rcsel.
- Select the lowest `rc'` ≥ `rc` such that `dest_addr[rc']` ≠ `next_router_address`. Here `dest_addr[k]` = `in_dest_info[k·router_addr_width +: router_addr_width]`.
- If such an `rc'` exists:
  - `d` is the lowest dimension where the two addresses differ.
  - Port = 2d if the destination digit is less than the current digit, otherwise 2d+1.
  - rcsel = `rc'`.
- If no such `rc'` exists, the flit ejects:
  - Port = 2·`num_dimensions` + node address. The node address is the low `node_addr_width` bits of `in_dest_info`, or 0 if `node_addr_width` = 0.
  - rcsel = `num_resource_classes`−1.
- Comparisons are unsigned per dimension digit. No wrap-around handling is needed because connectivity is line.

**Packet FSM**

- `IDLE`: an accepted head flit computes the route, latches it into `held_lar`, and goes to `IN_PKT` unless `in_tail` is also set.
- `IN_PKT`: accepted body and tail flits take `held_lar` as their `out_lar_info`. An accepted tail returns the FSM to `IDLE`.
- Inputs are ignored unless `in_valid && in_ready`.

**Buffer**

- Output register plus one skid entry, in FIFO order.
- `in_ready` = skid entry empty. It is a registered signal.
- A flit accepted while the output register is empty, or draining that same cycle, goes to the output register. Otherwise it goes to the skid entry.
- `head`, `tail`, `dest_info`, and the computed or held lar travel with the flit unchanged.

## Timing

- Latency: 1 cycle from input accept to `out_valid`.
- Sustained throughput: 1 flit/cycle while `out_ready` = 1.
- Output stall: a flit is presented with `out_valid`=1 and `out_ready`=0. Its output fields hold stable until accepted, and one more flit is accepted into the skid entry. The next cycle `in_ready`=0.
- Simultaneous accept on input and output with the skid entry empty: the output register is replaced in the same edge, with no bubble.
- Skid entry full and output drains: the skid entry moves to the output register, and `in_ready`=1 in the following cycle.
- Reset (`reset`=0, sampled on an edge):
  - FSM goes to `IDLE` and both entries are emptied.
  - `out_valid`=0, `in_ready`=1, `error`=0.
  - All data outputs and `held_lar` = 0.
  - Reset mid-packet discards in-flight flits with no further output.

## Configuration

- `RTR_LAR_PIPE_CHECK_EN` defined:
  - `error` is set on an accepted body or tail flit in `IDLE`, or an accepted head flit in `IN_PKT`. It stays set until reset.
  - Flits are still forwarded. An offending head restarts the packet; an offending body uses `held_lar`.
- Not defined: the checker logic is absent and `error` is tied to 0.

## Test plan

Addresses are written {dim0, dim1}, 2 bits each; defaults apply; lar is written {port[2:0], rc}.

- Head+tail, `rc`=0, next={1,2}, dest0={0,2} -> one cycle later `out_lar_info`=0000 (port 0, rc 0).
- Head+tail, `rc`=0, next={1,2}, dest0={1,2}, dest1={3,2} -> `out_lar_info`=0011 (rc moves to 1, dim0 up, port 1).
- Head+tail, `rc`=1, next={1,2}, dest1={1,2} -> `out_lar_info`=1001 (eject, port 4).
- 4-flit packet with head dest0={1,0}, next={1,2}, `rc`=0, followed by body inputs carrying garbage dest info -> all four outputs have `out_lar_info`=0100, in order, back-to-back.
- Stream with `out_ready` low for 3 cycles -> exactly 2 flits buffered, `in_ready`=0 from the second stall cycle. On release, output order is preserved with no loss or duplication.
- With `RTR_LAR_PIPE_CHECK_EN`: a body flit in `IDLE` sets `error`=1 and it stays 1. A reset issued mid-packet gives `error`=0, `out_valid`=0, `in_ready`=1 on the next cycle.
